seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for signed two's-complement division.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic             trial_ge;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fin_quo, fin_rem;
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // One restoring step: shift {prem, dvd} left, trial-subtract the divisor.
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    trial_ge = (shifted >= {1'b0, dvs_q});
    step_rem = trial_ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], trial_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    mag_a   = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
    mag_b   = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
    fin_quo = qneg_q ? WIDTH'(-step_quo) : step_quo;
    fin_rem = rneg_q ? WIDTH'(-step_rem) : step_rem;
`else
    mag_a   = dividend;
    mag_b   = divisor;
    fin_quo = step_quo;
    fin_rem = step_rem;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          prem_d = '0;
          dvd_d  = mag_a;
          dvs_d  = mag_b;
`ifdef SEQ_DIVIDER_SIGNED_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // Zero divisor bypasses the iteration entirely.
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d = step_rem;
        dvd_d  = step_quo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = fin_quo;
          rem_d   = fin_rem;
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on done.
module tb_seq_divider;
  localparam int unsigned W = 8;
  localparam int N_OPS = 3000;

  logic clk = 1'b0;
  logic rst, start, busy, done, div_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int cyc = 0;
  int next_ok = 0;
  int busy_until = -1;
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [W-1:0] last_q, last_r;
  logic last_dz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      dz = 1'b0;
    end
  endfunction

  // One cycle of stimulus; the model decides acceptance from when the divider is free.
  task automatic drive_cycle(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int lat;
    @(negedge clk);
    start = s; dividend = a; divisor = b;
    @(posedge clk);
    if (s && !rst && cyc >= next_ok) begin
      model(a, b, e.q, e.r, e.dz);
      lat = (b == '0) ? 1 : int'(W) + 1;
      // done is registered: it appears after edge cyc+lat-1 and is captured at cyc+lat.
      e.due = cyc + lat - 1;
      sb_q.push_back(e);
      busy_until = cyc + lat - 1;
      next_ok = cyc + lat + 1;
      accepted++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && (cyc < next_ok || sb_q.size() != 0); i++)
      drive_cycle(1'b0, W'($urandom), W'($urandom));
    chk("drain", sb_q.size(), 0);
    #1;
  endtask

  task automatic expect_const(input string nm, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic dz);
    chk({nm, "_quotient"}, quotient, q);
    chk({nm, "_remainder"}, remainder, r);
    chk({nm, "_div_zero"}, div_zero, dz);
  endtask

  task automatic expect_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    expect_const(nm, '0, '0, 1'b0);
  endtask

  // Monitor: busy tracking, result checks on done, hold checks otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_q = '0; last_r = '0; last_dz = 1'b0;
    end else begin
      chk("busy", busy, (cyc - 1 <= busy_until));
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want done=0 (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("quotient", quotient, mon_e.q);
          chk("remainder", remainder, mon_e.r);
          chk("div_zero", div_zero, mon_e.dz);
          chk("done_edge", cyc - 1, mon_e.due);
          last_q = mon_e.q; last_r = mon_e.r; last_dz = mon_e.dz;
        end
      end else begin
        chk("hold_quotient", quotient, last_q);
        chk("hold_remainder", remainder, last_r);
        chk("hold_div_zero", div_zero, last_dz);
      end
    end
  end

  initial begin
    logic s;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 expect_all_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    drive_cycle(1'b1, 8'h9C, 8'd7);
    wait_idle();
    expect_const("neg100_div_7", 8'hF2, 8'hFE, 1'b0);
    drive_cycle(1'b1, 8'h80, 8'hFF);
    wait_idle();
    expect_const("min_div_neg1", 8'h80, 8'h00, 1'b0);
`else
    drive_cycle(1'b1, 8'd200, 8'd7);
    wait_idle();
    expect_const("200_div_7", 8'd28, 8'd4, 1'b0);
`endif

    drive_cycle(1'b1, 8'd5, 8'd0);
    wait_idle();
    expect_const("5_div_0", 8'hFF, 8'd5, 1'b1);

    // Starts issued while busy must be dropped.
    drive_cycle(1'b1, 8'd255, 8'd1);
    drive_cycle(1'b0, 8'd0, 8'd0);
    drive_cycle(1'b1, 8'd9, 8'd3);
    drive_cycle(1'b0, 8'd0, 8'd0);
    drive_cycle(1'b1, 8'd9, 8'd3);
    wait_idle();
    expect_const("busy_ignore", 8'hFF, 8'd0, 1'b0);

    // Reset mid-operation aborts without a done pulse.
    drive_cycle(1'b1, 8'd200, 8'd7);
    repeat (3) drive_cycle(1'b0, 8'd200, 8'd7);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 expect_all_zero("midop_reset");
    sb_q.delete();
    next_ok = 0;
    busy_until = -1;
    @(posedge clk);
    #2 rst = 1'b0;
    drive_cycle(1'b1, 8'd100, 8'd10);
    wait_idle();
    expect_const("100_div_10", 8'd10, 8'd0, 1'b0);

    // Randomized traffic, start often held high for back-to-back operations.
    for (int n = 0; n < 60000 && accepted < N_OPS; n++) begin
      s = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      drive_cycle(s, a, b);
    end
    chk("ops_accepted", (accepted >= N_OPS), 1);
    wait_idle();
    drive_cycle(1'b0, 8'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
